// File: rtl/tlb_op_sequencer.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR from WB against the shared TLB and CP0,
// arbitrates the single TLB search port, and redirects pre-IF after TLB state changes.
module tlb_op_sequencer #(
  parameter int TLBNUM       = 16,
  parameter int TLBNUM_WIDTH = $clog2(TLBNUM),
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    req_valid,
  input  logic [1:0]              req_op,
  input  logic [31:0]             req_pc,
  output logic                    req_ready,
  input  logic                    flush,
  output logic                    busy,
  input  logic                    mem_s_req,
  input  logic [18:0]             mem_s_vpn2,
  input  logic [7:0]              mem_s_asid,
  output logic                    mem_s_grant,
  input  logic [18:0]             ehi_vpn2,
  input  logic [7:0]              ehi_asid,
  output logic [18:0]             s_vpn2,
  output logic [7:0]              s_asid,
  input  logic                    s_found,
  input  logic [TLBNUM_WIDTH-1:0] s_index,
  output logic                    cp0_tlbp,
  output logic [TLBNUM_WIDTH:0]   cp0_tlbp_result,
  output logic                    cp0_tlbr,
  output logic                    tlb_we,
  output logic                    tlb_wr_random,
  output logic                    refetch_valid,
  output logic [31:0]             refetch_pc,
  input  logic                    refetch_ready
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] OP_TLBP  = 2'b00;
  localparam logic [1:0] OP_TLBR  = 2'b01;
  localparam logic [1:0] OP_TLBWI = 2'b10;
  localparam logic [1:0] OP_TLBWR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_PDONE,
    S_READ,
    S_WRITE,
    S_REFETCH
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [1:0]            op_q;
  logic [31:0]           pc_q;
  logic [CNT_W-1:0]      starve_cnt;
  logic [TLBNUM_WIDTH:0] result_q;

  logic accept;
  logic starved;
  logic tlbp_grant;

  assign accept     = (state == S_IDLE) && req_valid && !flush;
  assign starved    = (starve_cnt == CNT_W'(STARVE_LIMIT));
  // TLBP takes the port when MEM is idle, or by force once it has waited long enough.
  assign tlbp_grant = (state == S_ARB) && (!mem_s_req || starved);

  assign s_vpn2      = tlbp_grant ? ehi_vpn2 : mem_s_vpn2;
  assign s_asid      = tlbp_grant ? ehi_asid : mem_s_asid;
  assign mem_s_grant = !tlbp_grant;

  assign req_ready       = (state == S_IDLE);
  assign busy            = (state != S_IDLE);
  assign refetch_pc      = pc_q + 32'd4;
  assign cp0_tlbp_result = result_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of block ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q       <= OP_TLBP;
      pc_q       <= '0;
      starve_cnt <= '0;
      result_q   <= '0;
    end else begin
      if (accept) begin
        op_q <= req_op;
        pc_q <= req_pc;
      end
      if (accept && (req_op == OP_TLBP)) begin
        starve_cnt <= '0;
      end else if ((state == S_ARB) && !tlbp_grant && !starved) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
      if (tlbp_grant && !flush) begin
        result_q <= {~s_found, s_index};
      end
    end
  end

  // NOTE: every output of this block gets a default first so no path through
  // the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_nxt     = state;
    cp0_tlbp      = 1'b0;
    cp0_tlbr      = 1'b0;
    tlb_we        = 1'b0;
    tlb_wr_random = 1'b0;
    refetch_valid = 1'b0;

    case (state)
      S_IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_TLBP:  state_nxt = S_ARB;
            OP_TLBR:  state_nxt = S_READ;
            OP_TLBWI: state_nxt = S_WRITE;
            OP_TLBWR: state_nxt = S_WRITE;
            default:  state_nxt = S_IDLE;
          endcase
        end
      end
      S_ARB: begin
        if (tlbp_grant) state_nxt = S_PDONE;
      end
      S_PDONE: begin
        cp0_tlbp  = 1'b1;
        state_nxt = S_IDLE;
      end
      S_READ: begin
        cp0_tlbr  = 1'b1;
        state_nxt = S_REFETCH;
      end
      S_WRITE: begin
        tlb_we        = 1'b1;
        tlb_wr_random = (op_q == OP_TLBWR);
        state_nxt     = S_REFETCH;
      end
      S_REFETCH: begin
        refetch_valid = 1'b1;
        if (refetch_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // An exception or eret kills whatever is in flight, including this cycle's strobe.
    if (flush) begin
      state_nxt     = S_IDLE;
      cp0_tlbp      = 1'b0;
      cp0_tlbr      = 1'b0;
      tlb_we        = 1'b0;
      tlb_wr_random = 1'b0;
      refetch_valid = 1'b0;
    end
  end

endmodule
